// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled 8-bit frames with optional even parity, feeding
// a small receive FIFO with a valid/ready read port. Errors are single-cycle pulses.
module uart_rx_core #(
    parameter int unsigned DivWidth  = 16,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DivWidth-1:0] div_i,
    input  logic                parity_en_i,
    input  logic                rx_i,
    output logic [7:0]          rdata_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic                busy_o,
    output logic                frame_err_o,
    output logic                parity_err_o,
    output logic                overrun_o
);

    // state     | meaning
    // S_IDLE    | waiting for a falling edge on the synchronized line
    // S_START   | qualifying the start bit at its midpoint
    // S_DATA    | sampling 8 data bits, LSB first
    // S_PARITY  | sampling the even-parity bit
    // S_STOP    | sampling the stop bit, then push or flag an error
    // S_WAIT_HIGH | framing error seen; line must return high before re-arming
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    localparam int unsigned AW = $clog2(FifoDepth);

    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic fall_edge;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall_edge = rx_prev_q & ~rx_s_q;

    state_e state_q, state_d;
    logic [DivWidth-1:0] cyc_q, cyc_d;
    logic [DivWidth-1:0] div_m1;
    logic [3:0] os_q, os_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic par_err_q, par_err_d;
    logic div_en, start_det, tick;
    logic push, fe, pe;

    assign div_en    = (div_i != '0);
    assign div_m1    = div_i - DivWidth'(1);
    assign start_det = (state_q == S_IDLE) && fall_edge && div_en;

    // ">=" rather than "==" so a divisor shrunk mid-count still wraps promptly
    always_comb begin
        tick  = 1'b0;
        cyc_d = cyc_q + DivWidth'(1);
        if (!div_en || start_det) begin
            cyc_d = '0;
        end else if (cyc_q >= div_m1) begin
            tick  = 1'b1;
            cyc_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        os_d      = tick ? os_q + 4'd1 : os_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        push      = 1'b0;
        fe        = 1'b0;
        pe        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_det) state_d = S_START;
            end
            S_START: begin
                if (tick && os_q == 4'd7) begin
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && os_q == 4'd15) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        par_err_d = 1'b0;
                        state_d   = parity_en_i ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick && os_q == 4'd15) begin
                    par_err_d = rx_s_q ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && os_q == 4'd15) begin
                    if (!rx_s_q) begin
                        fe      = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end else if (par_err_q) begin
                        pe      = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!div_en) state_d = S_IDLE;
        if (state_d != state_q) os_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            os_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            os_q      <= os_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
        end
    end

    logic [7:0] mem_q [FifoDepth];
    logic [AW:0] wptr_q, rptr_q;
    logic full, empty, pop, wr;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = ~empty & rready_i;
    // a pop in the same cycle frees the slot, so a push while full still lands
    assign wr    = push & (~full | pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
        end else begin
            if (wr) begin
                mem_q[wptr_q[AW-1:0]] <= shift_q;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

    assign rdata_o      = mem_q[rptr_q[AW-1:0]];
    assign rvalid_o     = ~empty;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_err_o  = fe;
    assign parity_err_o = pe;
    assign overrun_o    = push & full & ~pop;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames at div_i=4 (64 clocks per bit);
// expected bytes are queued at send time and checked by a monitor on every pop.
module tb_uart_rx_core;

    localparam int BIT = 64;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] div_i;
    logic        parity_en_i;
    logic        rx_i;
    logic [7:0]  rdata_o;
    logic        rvalid_o;
    logic        rready_i;
    logic        busy_o;
    logic        frame_err_o;
    logic        parity_err_o;
    logic        overrun_o;

    uart_rx_core #(.DivWidth(16), .FifoDepth(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .div_i        (div_i),
        .parity_en_i  (parity_en_i),
        .rx_i         (rx_i),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int pe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, expv);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (frame_err_o)  fe_cnt++;
            if (parity_err_o) pe_cnt++;
            if (overrun_o)    ov_cnt++;
            if (rvalid_o && rready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: actual=0x%0h expected=none", rdata_o);
                end else begin
                    chk("rdata", {24'd0, rdata_o}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // leaves the line at the stop-bit level
    task automatic send_frame(input logic [7:0] d, input bit par, input logic p, input logic stop);
        rx_i = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            idle(BIT);
        end
        if (par) begin
            rx_i = p;
            idle(BIT);
        end
        rx_i = stop;
        idle(BIT);
    endtask

    task automatic send(input logic [7:0] d, input bit par);
        send_frame(d, par, ^d, 1'b1);
        rx_i = 1'b1;
    endtask

    task automatic clr_cnt();
        fe_cnt = 0;
        pe_cnt = 0;
        ov_cnt = 0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            idle(1);
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst_ni      = 1'b0;
        rx_i        = 1'b1;
        div_i       = 16'd4;
        parity_en_i = 1'b0;
        rready_i    = 1'b1;
        idle(3);
        chk("reset_rdata",  {24'd0, rdata_o}, 32'h00);
        chk("reset_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("reset_busy",   {31'd0, busy_o}, 32'd0);
        chk("reset_errs",   {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);
        rst_ni = 1'b1;
        idle(5);

        // 0x55, parity off, latency from start edge
        clr_cnt();
        exp_q.push_back(8'h55);
        lat = 0;
        fork
            send(8'h55, 1'b0);
            begin
                while (!rvalid_o && lat < 2000) begin
                    idle(1);
                    lat++;
                end
            end
        join
        chk("latency_window", {31'd0, (lat >= 600 && lat <= 620)}, 32'd1);
        idle(20);
        chk("busy_after_55", {31'd0, busy_o}, 32'd0);
        chk("no_err_55", fe_cnt + pe_cnt + ov_cnt, 0);
        drain("drain_55");

        // parity on: good then bad parity
        parity_en_i = 1'b1;
        clr_cnt();
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        idle(20);
        drain("drain_a5");
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        rx_i = 1'b1;
        idle(20);
        chk("parity_err_pulse", pe_cnt, 1);
        chk("parity_no_frame_err", fe_cnt, 0);
        chk("parity_no_byte", {31'd0, rvalid_o}, 32'd0);
        parity_en_i = 1'b0;

        // glitch on the start bit
        clr_cnt();
        rx_i = 1'b0;
        idle(20);
        chk("glitch_busy", {31'd0, busy_o}, 32'd1);
        rx_i = 1'b1;
        idle(60);
        chk("glitch_idle", {31'd0, busy_o}, 32'd0);
        chk("glitch_no_err", fe_cnt + pe_cnt, 0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b0);
        idle(20);
        drain("drain_3c");

        // framing error, line held low
        clr_cnt();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        idle(200);
        chk("frame_err_pulse", fe_cnt, 1);
        chk("frame_wait_high", {31'd0, busy_o}, 32'd1);
        chk("frame_no_byte", {31'd0, rvalid_o}, 32'd0);
        rx_i = 1'b1;
        idle(20);
        chk("frame_released", {31'd0, busy_o}, 32'd0);
        chk("frame_err_single", fe_cnt, 1);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b0);
        idle(20);
        drain("drain_7e");

        // overrun on the fifth byte
        clr_cnt();
        rready_i = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            if (d <= 4) exp_q.push_back(8'(d));
            send(8'(d), 1'b0);
            idle(10);
        end
        chk("overrun_pulse", ov_cnt, 1);
        chk("head_held", {24'd0, rdata_o}, 32'h01);
        rready_i = 1'b1;
        drain("drain_overrun");
        idle(2);
        chk("empty_after_pops", {31'd0, rvalid_o}, 32'd0);

        // full FIFO with a pop in the push cycle
        rready_i = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            exp_q.push_back(8'(d));
            send(8'(d), 1'b0);
            idle(10);
        end
        clr_cnt();
        exp_q.push_back(8'h06);
        fork
            send(8'h06, 1'b0);
            begin
                idle(610);
                rready_i = 1'b1;
                idle(1);
                rready_i = 1'b0;
            end
        join
        idle(10);
        chk("full_pop_no_overrun", ov_cnt, 0);
        chk("full_pop_count", exp_q.size(), 4);
        rready_i = 1'b1;
        drain("drain_full_pop");

        // div_i = 0 keeps the receiver idle
        div_i = 16'd0;
        rx_i = 1'b0;
        idle(100);
        chk("div0_idle", {31'd0, busy_o}, 32'd0);
        rx_i = 1'b1;
        idle(5);
        div_i = 16'd4;
        idle(5);

        // reset mid-DATA with a byte already buffered
        rready_i = 1'b0;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b0);
        idle(10);
        chk("prereset_valid", {31'd0, rvalid_o}, 32'd1);
        rx_i = 1'b0;
        idle(BIT);
        rx_i = 1'b0;
        idle(BIT);
        rx_i = 1'b1;
        idle(BIT / 2);
        chk("prereset_busy", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midreset_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("midreset_busy",   {31'd0, busy_o}, 32'd0);
        chk("midreset_rdata",  {24'd0, rdata_o}, 32'h00);
        exp_q.delete();
        idle(5);
        rst_ni = 1'b1;
        idle(5);
        chk("postreset_rvalid", {31'd0, rvalid_o}, 32'd0);
        rready_i = 1'b1;
        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b0);
        idle(20);
        drain("drain_c3");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
